wb_alu: RTL
===========

# wb_alu

Parametrised Wishbone B4 classic slave that performs arithmetic and logic for the frequency-counter datapath, including an iterative multiplier and restoring divider for period-to-frequency conversion. The CPU or sequencer loads two operands and an opcode through a register map, starts the operation, then polls status and reads the result. It attaches to the shared Wishbone bus as a single slave; upper address bits are decoded externally.

## Interface
- DATA_W, 32: operand, bus-data and result-half width; legal values 8, 16, 32.
- ADDR_W, 32: width of adr_i; only adr_i[4:2] is decoded.
- clk_i  in  1  system clock; all logic is on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- adr_i  in  ADDR_W  byte address.
- dat_i  in  DATA_W  write data.
- dat_o  out  DATA_W  read data; 0 when ack_o=0.
- we_i  in  1  1 = write.
- sel_i  in  DATA_W/8  byte enables.
- cyc_i  in  1  bus cycle valid.
- stb_i  in  1  strobe.
- ack_o  out  1  normal termination.
- err_o  out  1  error termination.
- rty_o  out  1  retry termination.

## Operation
- Register map (word offset adr_i[4:2]):
  - 0 OPA (RW)
  - 1 OPB (RW)
  - 2 CTRL (RW): [3:0] op, [8] start. start is write-only and reads back 0.
  - 3 STATUS (RO except W1C): [0] busy, [1] done (sticky, W1C), [2] dz (div-by-zero, W1C).
  - 4 RES_LO (RO)
  - 5 RES_HI (RO)
  - 6 and 7 unmapped.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR: single cycle. Shift amount is OPB[$clog2(DATA_W)-1:0].
  - 7 MULU: unsigned shift-add, DATA_W iterations. RES_HI:RES_LO holds the 2·DATA_W-bit product.
  - 8 DIVU: restoring division, DATA_W iterations. RES_LO = quotient, RES_HI = remainder.
  - 9–15 are illegal.
- ADD and SUB: RES_LO = low DATA_W bits; RES_HI[0] = carry (ADD) or borrow (SUB); remaining bits 0. Logic and shift ops write RES_HI = 0.
- Writes to OPA and OPB honour sel_i per byte. CTRL writes require sel_i[0]; W1C writes to STATUS require sel_i[0].
- FSM states:
  - IDLE → EXEC on a start write with a legal op.
  - EXEC → DONE when the single-cycle op completes or the iteration counter reaches DATA_W-1.
  - DONE → IDLE unconditionally after one cycle.
  - In DONE: RES_LO/RES_HI are updated, done is set, busy is cleared.
- DIVU with OPB=0: no iterations. Next cycle gives RES_LO = all ones, RES_HI = OPA, dz=1, done=1.
- A start write sets done=0 and dz=0.
- Start write with an illegal op: err_o instead of ack_o; no state change.
- While busy:
  - Writes to OPA, OPB or CTRL get rty_o, with no effect.
  - STATUS and RES reads get ack_o; RES reads return the last completed result.
  - The engine works on internal copies of the operands; RES_LO/RES_HI change only in DONE.
- Any access to offsets 6 or 7, or a write to RES_LO/RES_HI: err_o.

## Timing
- Reset values: ack_o=0, err_o=0, rty_o=0, dat_o=0. All registers 0, FSM=IDLE, busy=0, done=0, dz=0.
- Bus handshake:
  - An access is taken at edge E when cyc_i&stb_i&!(ack_o|err_o|rty_o).
  - Exactly one of ack_o/err_o/rty_o is high for the cycle after E; dat_o is valid in that same cycle.
  - The termination signal drops for one cycle even if stb_i is held, so a back-to-back access costs 2 cycles.
- Register writes commit at E.
- A start write at E0 gives busy=1 from E0.
  - Single-cycle ops: result is registered at E1 (EXEC), with done=1 and busy=0 at E2 (DONE).
  - MULU/DIVU: iterations run at E1..E_DATA_W; done=1 at E_(DATA_W+1).
- A done W1C in the same cycle as DONE: set wins.
- rst_i asserted mid-operation: at the next edge the FSM aborts, every register is zeroed, and any pending termination is dropped.

## Structure
- Package wb_alu_pkg holds: opcode localparams, register-offset localparams, STATUS bit indices, and the FSM state typedef.
- One sub-module, alu_muldiv_iter, contains the shared iterative engine:
  - Inputs: start, mode (mul/div), operands.
  - Outputs: 2·DATA_W result, done pulse.
  - One counter of width $clog2(DATA_W).
- The top level owns bus decode, registers, the FSM and the single-cycle ops.

## Test plan
- Reset, then read STATUS → ack_o, dat_o=0. Read offset 6 → err_o=1, ack_o=0.
- OPA=0xFFFF_FFFF, OPB=1, ADD start → done after 2 cycles; RES_LO=0, RES_HI=1. SUB with OPA=0, OPB=1 → RES_LO=0xFFFF_FFFF, RES_HI=1.
- MULU with 0xFFFF_FFFF × 0xFFFF_FFFF → RES_HI=0xFFFF_FFFE, RES_LO=0x0000_0001; done exactly 33 cycles after the start edge.
- DIVU 100_000_000/7 → RES_LO=14_285_714, RES_HI=2. DIVU x/0 with OPA=5 → RES_LO=all ones, RES_HI=5, dz=1.
- Write OPA during a MULU → rty_o, OPA unchanged, product computed from the old operands. Write CTRL op=12 → err_o.
- rst_i pulsed mid-DIVU → busy=0, RES=0; a new DIVU 9/3 then yields 3 rem 0. DATA_W=8 instance: MULU 0xFF×0xFF → RES_HI=0xFE, RES_LO=0x01.

Source files
------------

// File: rtl/wb_alu_pkg.sv
// Shared definitions for the wb_alu Wishbone arithmetic slave: opcodes,
// register offsets, STATUS bit positions and the control FSM state type.
package wb_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_MULU = 4'd7;
  localparam logic [3:0] OP_DIVU = 4'd8;

  localparam logic [2:0] REG_OPA    = 3'd0;
  localparam logic [2:0] REG_OPB    = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_RES_LO = 3'd4;
  localparam logic [2:0] REG_RES_HI = 3'd5;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_DZ   = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_DIVU;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative engine shared by MULU (shift-add) and DIVU (restoring division);
// one result bit per cycle, DATA_W cycles per operation.
module alu_muldiv_iter
  import wb_alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  div_i,
  input  logic [DATA_W-1:0]     a_i,
  input  logic [DATA_W-1:0]     b_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  done_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic              run_q, run_d, div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] op_q, op_d, hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W:0]   sum_w, rem_w, diff_w;
  logic              ge_w;

  // hi:lo is the product accumulator for MULU and remainder:quotient for DIVU.
  always_comb begin
    sum_w  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_q} : '0);
    rem_w  = {hi_q, lo_q[DATA_W-1]};
    diff_w = rem_w - {1'b0, op_q};
    ge_w   = rem_w >= {1'b0, op_q};
    run_d  = run_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (start_i) begin
      run_d = 1'b1;
      div_d = div_i;
      cnt_d = '0;
      op_d  = div_i ? b_i : a_i;
      hi_d  = '0;
      lo_d  = div_i ? a_i : b_i;
    end else if (run_q) begin
      if (div_q) begin
        hi_d = ge_w ? diff_w[DATA_W-1:0] : rem_w[DATA_W-1:0];
        lo_d = {lo_q[DATA_W-2:0], ge_w};
      end else begin
        {hi_d, lo_d} = {sum_w, lo_q[DATA_W-1:1]};
      end
      if (cnt_q == LAST) run_d = 1'b0;
      else               cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_q <= 1'b0;
      div_q <= 1'b0;
      cnt_q <= '0;
      op_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      run_q <= run_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      op_q  <= op_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign done_o   = run_q && (cnt_q == LAST);
  assign result_o = {hi_q, lo_q};

endmodule

// File: rtl/wb_alu.sv
// Wishbone B4 classic slave wrapping single-cycle ALU ops plus the shared
// iterative multiply/divide engine behind a small register map.
module wb_alu
  import wb_alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADDR_W-1:0]   adr_i,
  input  logic [DATA_W-1:0]   dat_i,
  output logic [DATA_W-1:0]   dat_o,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] sel_i,
  input  logic                cyc_i,
  input  logic                stb_i,
  output logic                ack_o,
  output logic                err_o,
  output logic                rty_o
);

  localparam int SH_W = $clog2(DATA_W);
  // An 8-bit bus has no bit 8, so the start flag folds down to bit 7 there.
  localparam int START_BIT = (DATA_W > 8) ? 8 : 7;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [DATA_W-1:0]   res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic [DATA_W-1:0]   pend_lo_q, pend_lo_d, pend_hi_q, pend_hi_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic [3:0]          op_q, op_d;
  logic                done_q, done_d, dz_q, dz_d;
  logic                ack_q, ack_d, err_q, err_d, rty_q, rty_d;
  logic                take, busy, start_go, eng_start, eng_done, use_eng, div0;
  logic [2:0]          off;
  logic [2*DATA_W-1:0] eng_res;
  logic [DATA_W:0]     add_w, sub_w;
  logic                unused_adr;

  assign off        = adr_i[4:2];
  assign unused_adr = ^{adr_i[ADDR_W-1:5], adr_i[1:0]};
  assign busy       = state_q != S_IDLE;
  assign take       = cyc_i && stb_i && !(ack_q || err_q || rty_q);
  assign start_go   = take && we_i && !busy && off == REG_CTRL && sel_i[0]
                      && dat_i[START_BIT] && op_legal(dat_i[3:0]);
  assign eng_start  = start_go && (dat_i[3:0] == OP_MULU ||
                                   (dat_i[3:0] == OP_DIVU && opb_q != '0));
  assign div0       = op_q == OP_DIVU && opb_q == '0;
  assign use_eng    = op_q == OP_MULU || (op_q == OP_DIVU && !div0);

  alu_muldiv_iter #(.DATA_W(DATA_W)) u_iter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (eng_start),
    .div_i    (dat_i[3:0] == OP_DIVU),
    .a_i      (opa_q),
    .b_i      (opb_q),
    .result_o (eng_res),
    .done_o   (eng_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_go) state_d = S_EXEC;
      S_EXEC:  if (!use_eng || eng_done) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
  always_comb begin
    opa_d     = opa_q;
    opb_d     = opb_q;
    op_d      = op_q;
    res_lo_d  = res_lo_q;
    res_hi_d  = res_hi_q;
    pend_lo_d = pend_lo_q;
    pend_hi_d = pend_hi_q;
    done_d    = done_q;
    dz_d      = dz_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rty_d     = 1'b0;
    dat_d     = '0;
    add_w     = {1'b0, opa_q} + {1'b0, opb_q};
    sub_w     = {1'b0, opa_q} - {1'b0, opb_q};

    if (take) begin
      if (off > REG_RES_HI || (we_i && (off == REG_RES_LO || off == REG_RES_HI))) begin
        err_d = 1'b1;
      end else if (!we_i) begin
        ack_d = 1'b1;
        case (off)
          REG_OPA:    dat_d = opa_q;
          REG_OPB:    dat_d = opb_q;
          REG_CTRL:   dat_d = DATA_W'(op_q);
          REG_STATUS: dat_d = DATA_W'({dz_q, done_q, busy});
          REG_RES_LO: dat_d = res_lo_q;
          REG_RES_HI: dat_d = res_hi_q;
          default:    dat_d = '0;
        endcase
      end else if (off == REG_STATUS) begin
        ack_d = 1'b1;
        if (sel_i[0] && dat_i[ST_DONE]) done_d = 1'b0;
        if (sel_i[0] && dat_i[ST_DZ])   dz_d   = 1'b0;
      end else if (busy) begin
        rty_d = 1'b1;
      end else if (off == REG_CTRL && sel_i[0] && dat_i[START_BIT] && !op_legal(dat_i[3:0])) begin
        err_d = 1'b1;
      end else begin
        ack_d = 1'b1;
        for (int b = 0; b < DATA_W/8; b++) begin
          if (sel_i[b] && off == REG_OPA) opa_d[8*b +: 8] = dat_i[8*b +: 8];
          if (sel_i[b] && off == REG_OPB) opb_d[8*b +: 8] = dat_i[8*b +: 8];
        end
        if (off == REG_CTRL && sel_i[0]) begin
          op_d = dat_i[3:0];
          if (dat_i[START_BIT]) begin
            done_d = 1'b0;
            dz_d   = 1'b0;
          end
        end
      end
    end

    if (state_q == S_EXEC) begin
      pend_hi_d = '0;
      case (op_q)
        OP_ADD:  begin pend_lo_d = add_w[DATA_W-1:0]; pend_hi_d[0] = add_w[DATA_W]; end
        OP_SUB:  begin pend_lo_d = sub_w[DATA_W-1:0]; pend_hi_d[0] = sub_w[DATA_W]; end
        OP_AND:  pend_lo_d = opa_q & opb_q;
        OP_OR:   pend_lo_d = opa_q | opb_q;
        OP_XOR:  pend_lo_d = opa_q ^ opb_q;
        OP_SHL:  pend_lo_d = opa_q << opb_q[SH_W-1:0];
        OP_SHR:  pend_lo_d = opa_q >> opb_q[SH_W-1:0];
        OP_DIVU: begin pend_lo_d = '1; pend_hi_d = opa_q; end
        default: pend_lo_d = '0;
      endcase
    end

    // Placed after the W1C handling so a set in DONE wins over a same-cycle clear.
    if (state_q == S_DONE) begin
      res_lo_d = use_eng ? eng_res[DATA_W-1:0]      : pend_lo_q;
      res_hi_d = use_eng ? eng_res[2*DATA_W-1:DATA_W] : pend_hi_q;
      done_d   = 1'b1;
      dz_d     = div0;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      opa_q     <= '0;
      opb_q     <= '0;
      op_q      <= '0;
      res_lo_q  <= '0;
      res_hi_q  <= '0;
      pend_lo_q <= '0;
      pend_hi_q <= '0;
      dat_q     <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rty_q     <= 1'b0;
    end else begin
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      op_q      <= op_d;
      res_lo_q  <= res_lo_d;
      res_hi_q  <= res_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_hi_q <= pend_hi_d;
      dat_q     <= dat_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rty_q     <= rty_d;
    end
  end

  assign dat_o = dat_q;
  assign ack_o = ack_q;
  assign err_o = err_q;
  assign rty_o = rty_q;

endmodule
